// File: rtl/rf_pkg.sv
// Shared register-file definitions: address/data widths, the zero register and the
// writeback entry payload used by the write queue.
package rf_pkg;

  localparam int unsigned RF_AW = 5;
  localparam int unsigned RF_DW = 64;
  localparam logic [RF_AW-1:0] RF_ZERO_REG = 5'd31;

  typedef struct packed {
    logic [RF_AW-1:0] rw;
    logic [RF_DW-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Pointer/count FIFO of writeback entries with full/empty flags. All storage is exposed
// so the owner can search pending entries in age order (oldest at i_rd_ptr).
module wb_fifo
  import rf_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PW    = $clog2(DEPTH),
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_push,
  input  logic                  i_pop,
  input  wb_entry_t             i_entry,
  output wb_entry_t             o_head,
  output wb_entry_t [DEPTH-1:0] o_mem,
  output logic      [PW-1:0]    o_rd_ptr,
  output logic      [CW-1:0]    o_count,
  output logic                  o_full,
  output logic                  o_empty
);

  wb_entry_t [DEPTH-1:0] r_mem;
  logic      [PW-1:0]    r_wr_ptr;
  logic      [PW-1:0]    r_rd_ptr;
  logic      [CW-1:0]    r_count;

  // Payload storage carries no reset; only entries covered by r_count are meaningful.
  always_ff @(posedge i_clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_entry;
    end
  end

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      if (i_push && !i_pop)      r_count <= r_count + CW'(1);
      else if (!i_push && i_pop) r_count <= r_count - CW'(1);
    end
  end

  assign o_head   = r_mem[r_rd_ptr];
  assign o_mem    = r_mem;
  assign o_rd_ptr = r_rd_ptr;
  assign o_count  = r_count;
  assign o_full   = (r_count == CW'(DEPTH));
  assign o_empty  = (r_count == '0);

endmodule

// File: rtl/reg_write_queue.sv
// Writeback queue feeding the regfile write port one entry per cycle through a registered
// output stage. Define WB_BYPASS_EN to add the pending-write lookup ports (Lk*/Hit*/Fwd*).
module reg_write_queue
  import rf_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DW    = RF_DW,
  parameter int unsigned AW    = RF_AW
) (
  input  logic          Clk,
  input  logic          Rst_n,
  input  logic          InValid,
  output logic          InReady,
  input  logic [AW-1:0] InRW,
  input  logic [DW-1:0] InData,
  input  logic          DrainEn,
  output logic          RegWr,
  output logic [AW-1:0] RW,
  output logic [DW-1:0] BusW,
`ifdef WB_BYPASS_EN
  input  logic [AW-1:0] LkA,
  input  logic [AW-1:0] LkB,
  output logic          HitA,
  output logic          HitB,
  output logic [DW-1:0] FwdA,
  output logic [DW-1:0] FwdB,
`endif
  output logic          Empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  wb_entry_t             w_in_entry;
  wb_entry_t             w_head;
  wb_entry_t [DEPTH-1:0] w_mem;
  logic      [PW-1:0]    w_rd_ptr;
  logic      [CW-1:0]    w_count;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_push;
  logic                  w_pop;

  logic                  r_reg_wr;
  logic      [AW-1:0]    r_rw;
  logic      [DW-1:0]    r_bus_w;

  // Writes to the zero register complete the handshake but are dropped.
  assign w_in_entry.rw   = RF_AW'(InRW);
  assign w_in_entry.data = RF_DW'(InData);
  assign w_push = InValid && !w_full && (w_in_entry.rw != RF_ZERO_REG);
  assign w_pop  = DrainEn && !w_empty;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk    (Clk),
    .i_rst_n  (Rst_n),
    .i_push   (w_push),
    .i_pop    (w_pop),
    .i_entry  (w_in_entry),
    .o_head   (w_head),
    .o_mem    (w_mem),
    .o_rd_ptr (w_rd_ptr),
    .o_count  (w_count),
    .o_full   (w_full),
    .o_empty  (w_empty)
  );

  // Output stage: address/data hold their last value while RegWr is low.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      r_reg_wr <= 1'b0;
      r_rw     <= '0;
      r_bus_w  <= '0;
    end else begin
      r_reg_wr <= w_pop;
      if (w_pop) begin
        r_rw    <= AW'(w_head.rw);
        r_bus_w <= DW'(w_head.data);
      end
    end
  end

  assign RegWr   = r_reg_wr;
  assign RW      = r_rw;
  assign BusW    = r_bus_w;
  assign InReady = !w_full;
  assign Empty   = w_empty && !r_reg_wr;

`ifdef WB_BYPASS_EN
  // Scan oldest to newest so the youngest match overrides: output stage, then queue.
  function automatic logic [RF_DW:0] f_lookup(
    input logic      [AW-1:0]    lk,
    input logic                  stage_vld,
    input logic      [AW-1:0]    stage_rw,
    input logic      [DW-1:0]    stage_data,
    input wb_entry_t [DEPTH-1:0] mem,
    input logic      [PW-1:0]    rd_ptr,
    input logic      [CW-1:0]    count
  );
    logic             hit;
    logic [RF_DW-1:0] data;
    logic [PW-1:0]    idx;
    hit  = 1'b0;
    data = '0;
    if (RF_AW'(lk) != RF_ZERO_REG) begin
      if (stage_vld && (stage_rw == lk)) begin
        hit  = 1'b1;
        data = RF_DW'(stage_data);
      end
      for (int unsigned i = 0; i < DEPTH; i++) begin
        idx = PW'(rd_ptr + PW'(i));
        if ((CW'(i) < count) && (mem[idx].rw == RF_AW'(lk))) begin
          hit  = 1'b1;
          data = mem[idx].data;
        end
      end
    end
    return {hit, data};
  endfunction

  logic [RF_DW:0] w_lk_a;
  logic [RF_DW:0] w_lk_b;

  always_comb begin
    w_lk_a = f_lookup(LkA, r_reg_wr, r_rw, r_bus_w, w_mem, w_rd_ptr, w_count);
    w_lk_b = f_lookup(LkB, r_reg_wr, r_rw, r_bus_w, w_mem, w_rd_ptr, w_count);
  end

  assign HitA = w_lk_a[RF_DW];
  assign HitB = w_lk_b[RF_DW];
  assign FwdA = DW'(w_lk_a[RF_DW-1:0]);
  assign FwdB = DW'(w_lk_b[RF_DW-1:0]);
`else
  logic w_unused_bypass;
  assign w_unused_bypass = ^{w_mem, w_rd_ptr, w_count};
`endif

endmodule
